compdiv: RTL

Sequential fixed-point complex divider for the uplink receiver's frequency-domain equalizer, computing a/b (for example, received symbol over channel estimate) on Q(INT_WIDTH).(FRAC_WIDTH) operands. It is the inverse operation of the FFT complex multiplier and uses the same operand and result format. A single request/response handshake accepts one division at a time. Latency is fixed, and both result components are produced by two restoring dividers that run in parallel and share one denominator.

---
 rtl/compdiv.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/compdiv.sv
// Sequential Q-format complex divider a/b for the frequency-domain equalizer.
// Two restoring dividers share one shifted denominator; latency is data-independent.
module compdiv #(
   parameter int DATA_WIDTH = 16,
   parameter int FRAC_WIDTH = 12,
   parameter int INT_WIDTH  = 4
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_valid,
   output logic                         o_ready,
   input  logic signed [DATA_WIDTH-1:0] i_a_re,
   input  logic signed [DATA_WIDTH-1:0] i_a_im,
   input  logic signed [DATA_WIDTH-1:0] i_b_re,
   input  logic signed [DATA_WIDTH-1:0] i_b_im,
   output logic                         o_valid,
   output logic signed [DATA_WIDTH-1:0] o_res_re,
   output logic signed [DATA_WIDTH-1:0] o_res_im,
   output logic                         o_div_by_zero
);

   localparam int PW = 2 * DATA_WIDTH + 1;
   localparam int RW = PW + DATA_WIDTH;
   localparam int QW = INT_WIDTH + FRAC_WIDTH - 1;
   localparam int CW = $clog2(DATA_WIDTH);
   localparam logic [CW-1:0] CNT_TOP = CW'(QW - 1);
   localparam logic [DATA_WIDTH-1:0] MAXPOS = {1'b0, {(DATA_WIDTH-1){1'b1}}};

   typedef enum logic [1:0] {IDLE, PREP, DIV, DONE} state_t;
   state_t state, next_state;

   logic signed [DATA_WIDTH-1:0] a_re, a_im, b_re, b_im;
   logic signed [PW-1:0] ar, ai, br, bi, num_re, num_im;
   logic [PW-1:0] den, mag_re, mag_im;
   logic [RW-1:0] dvd_re, dvd_im, den_lim, den_start;
   logic [RW-1:0] rem_re, rem_im, dsh;
   logic [QW-1:0] q_re, q_im;
   logic [CW-1:0] cnt;
   logic neg_re, neg_im, ovf_re, ovf_im, zero_den;
   logic ge_re, ge_im;
   logic [DATA_WIDTH-1:0] res_re, res_im;

   assign ar = $signed({{(PW-DATA_WIDTH){a_re[DATA_WIDTH-1]}}, a_re});
   assign ai = $signed({{(PW-DATA_WIDTH){a_im[DATA_WIDTH-1]}}, a_im});
   assign br = $signed({{(PW-DATA_WIDTH){b_re[DATA_WIDTH-1]}}, b_re});
   assign bi = $signed({{(PW-DATA_WIDTH){b_im[DATA_WIDTH-1]}}, b_im});

   // Exact products in PW bits; den is a sum of squares and therefore non-negative
   assign num_re = ar * br + ai * bi;
   assign num_im = ai * br - ar * bi;
   assign den    = $unsigned(br * br + bi * bi);
   assign mag_re = num_re[PW-1] ? $unsigned(-num_re) : $unsigned(num_re);
   assign mag_im = num_im[PW-1] ? $unsigned(-num_im) : $unsigned(num_im);

   assign dvd_re    = {{(RW-PW-FRAC_WIDTH){1'b0}}, mag_re, {FRAC_WIDTH{1'b0}}};
   assign dvd_im    = {{(RW-PW-FRAC_WIDTH){1'b0}}, mag_im, {FRAC_WIDTH{1'b0}}};
   assign den_lim   = {1'b0, den, {(DATA_WIDTH-1){1'b0}}};
   assign den_start = {2'b00, den, {(DATA_WIDTH-2){1'b0}}};

   assign ge_re = rem_re >= dsh;
   assign ge_im = rem_im >= dsh;

   // Sign is reapplied to the magnitude quotient; overflow clamps symmetrically
   always_comb begin
      res_re = {1'b0, q_re};
      res_im = {1'b0, q_im};
      if (ovf_re) res_re = MAXPOS;
      if (ovf_im) res_im = MAXPOS;
      if (neg_re) res_re = -res_re;
      if (neg_im) res_im = -res_im;
   end

   always_comb begin
      next_state = state;
      o_ready    = 1'b0;
      case (state)
         IDLE: begin
            o_ready = 1'b1;
            if (i_valid) next_state = PREP;
         end
         PREP: next_state = DIV;
         DIV:  if (cnt == '0) next_state = DONE;
         DONE: next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= IDLE;
      else       state <= next_state;
   end

   // Datapath: operand capture, preparation, one quotient bit per DIV cycle, result latch
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         a_re <= '0; a_im <= '0; b_re <= '0; b_im <= '0;
         rem_re <= '0; rem_im <= '0; dsh <= '0;
         q_re <= '0; q_im <= '0; cnt <= '0;
         neg_re <= 1'b0; neg_im <= 1'b0; ovf_re <= 1'b0; ovf_im <= 1'b0;
         zero_den <= 1'b0;
         o_valid <= 1'b0; o_res_re <= '0; o_res_im <= '0; o_div_by_zero <= 1'b0;
      end else begin
         o_valid <= 1'b0;
         case (state)
            IDLE: if (i_valid) begin
               a_re <= i_a_re; a_im <= i_a_im; b_re <= i_b_re; b_im <= i_b_im;
            end
            PREP: begin
               rem_re   <= dvd_re;
               rem_im   <= dvd_im;
               dsh      <= den_start;
               neg_re   <= num_re[PW-1];
               neg_im   <= num_im[PW-1];
               ovf_re   <= dvd_re >= den_lim;
               ovf_im   <= dvd_im >= den_lim;
               zero_den <= den == '0;
               q_re     <= '0;
               q_im     <= '0;
               cnt      <= CNT_TOP;
            end
            DIV: begin
               if (ge_re) rem_re <= rem_re - dsh;
               if (ge_im) rem_im <= rem_im - dsh;
               q_re <= {q_re[QW-2:0], ge_re};
               q_im <= {q_im[QW-2:0], ge_im};
               dsh  <= dsh >> 1;
               if (cnt != '0) cnt <= cnt - 1'b1;
            end
            DONE: begin
               o_valid       <= 1'b1;
               o_div_by_zero <= zero_den;
               o_res_re      <= zero_den ? '0 : res_re;
               o_res_im      <= zero_den ? '0 : res_im;
            end
            default: ;
         endcase
      end
   end

endmodule
